// File: rtl/vocab_matcher_if.sv
// Handshake and vocabulary-write bundle for the vocabulary lookup engine.
interface vocab_matcher_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_WIDTH   = $clog2(WORD_LENGTH + 1)
);
    logic                              start;
    logic [WORD_LENGTH*DATA_WIDTH-1:0] word;
    logic [LEN_WIDTH-1:0]              word_len;
    logic                              mode;
    logic                              wr_en;
    logic [ADDR_WIDTH-1:0]             wr_addr;
    logic [WORD_LENGTH*DATA_WIDTH-1:0] wr_data;
    logic [LEN_WIDTH-1:0]              wr_len;
    logic                              busy;
    logic                              done;
    logic                              hit;
    logic [ADDR_WIDTH-1:0]             match_addr;
    logic [LEN_WIDTH-1:0]              match_len;
    logic                              null_end;
    logic                              overflow;

    modport master (
        output start, word, word_len, mode,
        output wr_en, wr_addr, wr_data, wr_len,
        input  busy, done, hit, match_addr, match_len,
        input  null_end, overflow
    );

    modport slave (
        input  start, word, word_len, mode,
        input  wr_en, wr_addr, wr_data, wr_len,
        output busy, done, hit, match_addr, match_len,
        output null_end, overflow
    );
endinterface

// File: rtl/vocab_matcher.sv
// Vocabulary lookup engine: writable entry table scanned one entry per
// cycle, exact-match or longest-prefix, reporting hit/null/overflow.
module vocab_matcher #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
    input logic            clk,
    input logic            rst_n,
    vocab_matcher_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WW    = WORD_LENGTH * DATA_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(WORD_LENGTH);

    function automatic logic [LEN_WIDTH-1:0] clamp_len(
        input logic [LEN_WIDTH-1:0] l
    );
        if ({1'b0, l} > (LEN_WIDTH + 1)'(WORD_LENGTH)) return MAX_LEN;
        return l;
    endfunction

    logic [WW-1:0]         mem_data [DEPTH];
    logic [LEN_WIDTH-1:0]  mem_len  [DEPTH];

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] scan_addr;
    logic [WW-1:0]         q_word;
    logic [LEN_WIDTH-1:0]  q_len;
    logic                  q_mode;

    logic                  res_hit;
    logic [ADDR_WIDTH-1:0] res_addr;
    logic [LEN_WIDTH-1:0]  res_len;
    logic                  res_null;
    logic                  res_ovf;

    logic                  busy;
    logic                  write_ok;
    logic [WW-1:0]         entry_data;
    logic [LEN_WIDTH-1:0]  entry_len;
    logic                  prefix_ok;
    logic                  is_null;
    logic                  exact_hit;
    logic                  pref_take;
    logic                  last;

    assign busy     = (state == SCAN);
    assign write_ok = bus.wr_en && !busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_len[a] <= '0;
            end
        end else if (write_ok) begin
            mem_len[bus.wr_addr] <= clamp_len(bus.wr_len);
        end
    end

    // Byte contents need no reset: a zero length marks the entry unused.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem_data[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign entry_data = mem_data[scan_addr];
    assign entry_len  = mem_len[scan_addr];

    always_comb begin
        prefix_ok = 1'b1;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if (LEN_WIDTH'(i) < entry_len &&
                entry_data[WW-1-i*DATA_WIDTH -: DATA_WIDTH] !=
                q_word[WW-1-i*DATA_WIDTH -: DATA_WIDTH]) begin
                prefix_ok = 1'b0;
            end
        end
    end

    assign is_null   = (entry_len == '0);
    assign exact_hit = !is_null && (entry_len == q_len) && prefix_ok;
    assign pref_take = !is_null && (entry_len <= q_len) && prefix_ok &&
                       (entry_len > res_len);
    assign last      = &scan_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            scan_addr <= '0;
            q_word    <= '0;
            q_len     <= '0;
            q_mode    <= 1'b0;
            res_hit   <= 1'b0;
            res_addr  <= '0;
            res_len   <= '0;
            res_null  <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        q_word    <= bus.word;
                        q_len     <= clamp_len(bus.word_len);
                        q_mode    <= bus.mode;
                        scan_addr <= '0;
                        res_hit   <= 1'b0;
                        res_addr  <= '0;
                        res_len   <= '0;
                        res_null  <= 1'b0;
                        res_ovf   <= 1'b0;
                        state     <= (bus.word_len == '0) ? DONE : SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (is_null) begin
                        res_null <= 1'b1;
                        res_hit  <= q_mode && (res_len != '0);
                        state    <= DONE;
                    end else if (!q_mode && exact_hit) begin
                        res_hit  <= 1'b1;
                        res_addr <= scan_addr;
                        res_len  <= entry_len;
                        state    <= DONE;
                    end else begin
                        // Strictly longer only, so ties keep the lower address.
                        if (q_mode && pref_take) begin
                            res_addr <= scan_addr;
                            res_len  <= entry_len;
                        end
                        if (last) begin
                            res_ovf <= 1'b1;
                            res_hit <= q_mode &&
                                       (pref_take || res_len != '0);
                            state   <= DONE;
                        end else begin
                            scan_addr <= scan_addr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = (state == DONE);
    assign bus.hit        = res_hit;
    assign bus.match_addr = res_addr;
    assign bus.match_len  = res_len;
    assign bus.null_end   = res_null;
    assign bus.overflow   = res_ovf;
endmodule

// File: tb/tb_vocab_matcher.sv
// Self-checking bench for vocab_matcher: directed scenarios plus random
// tables/queries against a behavioural lookup model.
module tb_vocab_matcher;
    localparam int AW    = 4;
    localparam int WL    = 3;
    localparam int DW    = 8;
    localparam int LW    = 2;
    localparam int DEPTH = 16;
    localparam int WW    = WL * DW;
    localparam int RW    = AW + LW + 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [WW-1:0] m_data [DEPTH];
    int            m_len  [DEPTH];

    vocab_matcher_if #(
        .ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) bus ();

    vocab_matcher #(
        .ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WW-1:0] w3(
        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c
    );
        return {a, b, c};
    endfunction

    function automatic logic [7:0] byte_of(input logic [WW-1:0] w, input int i);
        return w[WW-1-i*DW -: DW];
    endfunction

    function automatic bit same_prefix(
        input logic [WW-1:0] a, input logic [WW-1:0] b, input int n
    );
        for (int i = 0; i < n; i++) begin
            if (byte_of(a, i) != byte_of(b, i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Lookup as described: walk the table, stop on null/exact, track best prefix.
    function automatic void model(
        input logic [WW-1:0] w, input int wl, input bit m,
        output logic [RW-1:0] res, output int cyc
    );
        int q;
        int bl;
        int ba;
        int l;
        q   = (wl > WL) ? WL : wl;
        bl  = 0;
        ba  = 0;
        res = '0;
        cyc = 1;
        if (q == 0) return;
        for (int a = 0; a < DEPTH; a++) begin
            l = m_len[a];
            if (l == 0) begin
                cyc = a + 2;
                res = {bl != 0, AW'(ba), LW'(bl), 1'b1, 1'b0};
                return;
            end
            if (same_prefix(w, m_data[a], l)) begin
                if (!m && l == q) begin
                    cyc = a + 2;
                    res = {1'b1, AW'(a), LW'(l), 2'b00};
                    return;
                end
                if (m && l <= q && l > bl) begin
                    bl = l;
                    ba = a;
                end
            end
        end
        cyc = DEPTH + 1;
        res = {bl != 0, AW'(ba), LW'(bl), 1'b0, 1'b1};
    endfunction

    function automatic logic [RW-1:0] observed();
        return {bus.hit, bus.match_addr, bus.match_len, bus.null_end, bus.overflow};
    endfunction

    task automatic write_entry(input int a, input logic [WW-1:0] d, input int l);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        bus.wr_len  = LW'(l);
        @(negedge clk);
        bus.wr_en   = 1'b0;
        m_data[a]   = d;
        m_len[a]    = (l > WL) ? WL : l;
    endtask

    task automatic run_query(
        input logic [WW-1:0] w, input int wl, input bit m,
        output int cyc, output logic [RW-1:0] res, output int busy_err
    );
        bus.word     = w;
        bus.word_len = LW'(wl);
        bus.mode     = m;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc       = 1;
        busy_err  = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy !== 1'b1) busy_err++;
            @(negedge clk);
            cyc++;
        end
        if (bus.done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL query_timeout: done not seen after %0d cycles", cyc);
        end
        if (bus.busy !== 1'b0) busy_err++;
        res = observed();
    endtask

    task automatic test_reset();
        logic [RW+1:0] got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {bus.busy, bus.done, observed()};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        rst_n = 1'b1;
        @(negedge clk);
        got = {bus.busy, bus.done, observed()};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_idle: got %h want 0", got);
        end
        for (int a = 0; a < DEPTH; a++) m_len[a] = 0;
    endtask

    task automatic test_exact();
        int cyc;
        int be;
        logic [RW-1:0] res;
        logic [RW-1:0] held;
        write_entry(0, w3("H", "e", 8'h00), 2);
        write_entry(1, w3("H", "e", "l"), 3);
        write_entry(2, w3("H", 8'h00, 8'h00), 1);
        write_entry(3, w3(8'h00, 8'h00, 8'h00), 0);
        run_query(w3("H", "e", "l"), 3, 1'b0, cyc, res, be);
        total++;
        if (res !== {1'b1, 4'd1, 2'd3, 2'b00} || cyc != 3 || be != 0) begin
            bad++;
            $display("FAIL exact_hel: res %h cyc %0d busy_err %0d want %h cyc 3",
                     res, cyc, be, {1'b1, 4'd1, 2'd3, 2'b00});
        end
        held = res;
        @(negedge clk);
        total++;
        if ({bus.done, observed()} !== {1'b0, held}) begin
            bad++;
            $display("FAIL result_hold: done %b res %h want 0 %h",
                     bus.done, observed(), held);
        end
        run_query(w3("H", "e", "x"), 3, 1'b0, cyc, res, be);
        total++;
        if (res !== {1'b0, 4'd0, 2'd0, 2'b10} || cyc != 5) begin
            bad++;
            $display("FAIL exact_hex: res %h cyc %0d want %h cyc 5",
                     res, cyc, {1'b0, 4'd0, 2'd0, 2'b10});
        end
    endtask

    task automatic test_prefix();
        int cyc;
        int be;
        logic [RW-1:0] res;
        run_query(w3("H", "e", "l"), 3, 1'b1, cyc, res, be);
        total++;
        if (res !== {1'b1, 4'd1, 2'd3, 2'b10} || cyc != 5 || be != 0) begin
            bad++;
            $display("FAIL prefix_hel: res %h cyc %0d want %h cyc 5",
                     res, cyc, {1'b1, 4'd1, 2'd3, 2'b10});
        end
        run_query(w3("H", "e", "x"), 3, 1'b1, cyc, res, be);
        total++;
        if (res !== {1'b1, 4'd0, 2'd2, 2'b10} || cyc != 5) begin
            bad++;
            $display("FAIL prefix_hex: res %h cyc %0d want %h cyc 5",
                     res, cyc, {1'b1, 4'd0, 2'd2, 2'b10});
        end
    endtask

    task automatic test_overflow();
        int cyc;
        int be;
        logic [RW-1:0] res;
        for (int a = 0; a < DEPTH - 1; a++) write_entry(a, w3("a", "b", "c"), 3);
        write_entry(DEPTH - 1, w3("H", "e", "l"), 3);
        run_query(w3("H", "e", "l"), 3, 1'b0, cyc, res, be);
        total++;
        if (res !== {1'b1, 4'd15, 2'd3, 2'b00} || cyc != 17 || be != 0) begin
            bad++;
            $display("FAIL exact_last: res %h cyc %0d want %h cyc 17",
                     res, cyc, {1'b1, 4'd15, 2'd3, 2'b00});
        end
        run_query(w3("z", "z", "z"), 3, 1'b0, cyc, res, be);
        total++;
        if (res !== {1'b0, 4'd0, 2'd0, 2'b01} || cyc != 17) begin
            bad++;
            $display("FAIL overflow_zzz: res %h cyc %0d want %h cyc 17",
                     res, cyc, {1'b0, 4'd0, 2'd0, 2'b01});
        end
        run_query(w3("H", "e", "l"), 3, 1'b1, cyc, res, be);
        total++;
        if (res !== {1'b1, 4'd15, 2'd3, 2'b01} || cyc != 17) begin
            bad++;
            $display("FAIL prefix_last: res %h cyc %0d want %h cyc 17",
                     res, cyc, {1'b1, 4'd15, 2'd3, 2'b01});
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        int be;
        logic [RW-1:0] res;
        bus.word     = w3("z", "z", "z");
        bus.word_len = 2'd3;
        bus.mode     = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc       = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (cyc == 3) begin
                bus.wr_en    = 1'b1;
                bus.wr_addr  = 4'd0;
                bus.wr_data  = w3("q", "q", "q");
                bus.wr_len   = 2'd3;
                bus.start    = 1'b1;
                bus.word     = w3("a", "b", "c");
            end else begin
                bus.wr_en = 1'b0;
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        res       = observed();
        total++;
        if (res !== {1'b0, 4'd0, 2'd0, 2'b01} || cyc != 17) begin
            bad++;
            $display("FAIL busy_ignore: res %h cyc %0d want %h cyc 17",
                     res, cyc, {1'b0, 4'd0, 2'd0, 2'b01});
        end
        run_query(w3("a", "b", "c"), 3, 1'b0, cyc, res, be);
        total++;
        if (res !== {1'b1, 4'd0, 2'd3, 2'b00} || cyc != 2) begin
            bad++;
            $display("FAIL entry0_kept: res %h cyc %0d want %h cyc 2",
                     res, cyc, {1'b1, 4'd0, 2'd3, 2'b00});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int be;
        logic [RW-1:0] res;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = w3("x", "y", "z");
        bus.wr_len   = 2'd3;
        m_data[0]    = w3("x", "y", "z");
        m_len[0]     = 3;
        run_query(w3("x", "y", "z"), 3, 1'b0, cyc, res, be);
        bus.wr_en = 1'b0;
        total++;
        if (res !== {1'b1, 4'd0, 2'd3, 2'b00} || cyc != 2) begin
            bad++;
            $display("FAIL write_with_start: res %h cyc %0d want %h cyc 2",
                     res, cyc, {1'b1, 4'd0, 2'd3, 2'b00});
        end
        run_query(w3("a", "b", "c"), 3, 1'b0, cyc, res, be);
        total++;
        if (res !== {1'b1, 4'd1, 2'd3, 2'b00} || cyc != 3) begin
            bad++;
            $display("FAIL start_in_done: res %h cyc %0d want %h cyc 3",
                     res, cyc, {1'b1, 4'd1, 2'd3, 2'b00});
        end
    endtask

    task automatic test_reset_midscan();
        int cyc;
        int be;
        int seen;
        logic [RW-1:0] res;
        logic [RW+1:0] got;
        bus.word     = w3("z", "z", "z");
        bus.word_len = 2'd3;
        bus.mode     = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        got   = {bus.busy, bus.done, observed()};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL midscan_reset_outputs: got %h want 0", got);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL aborted_no_done: done seen %0d times want 0", seen);
        end
        for (int a = 0; a < DEPTH; a++) m_len[a] = 0;
        run_query(w3("a", "b", "c"), 3, 1'b0, cyc, res, be);
        total++;
        if (res !== {1'b0, 4'd0, 2'd0, 2'b10} || cyc != 2) begin
            bad++;
            $display("FAIL table_cleared: res %h cyc %0d want %h cyc 2",
                     res, cyc, {1'b0, 4'd0, 2'd0, 2'b10});
        end
    endtask

    task automatic test_zero_len();
        int cyc;
        int be;
        logic [RW-1:0] res;
        write_entry(0, w3("a", 8'h00, 8'h00), 1);
        run_query(w3("a", "b", "c"), 0, 1'b1, cyc, res, be);
        total++;
        if (res !== '0 || cyc != 1 || be != 0) begin
            bad++;
            $display("FAIL zero_len: res %h cyc %0d busy_err %0d want 0 cyc 1",
                     res, cyc, be);
        end
    endtask

    function automatic logic [7:0] rnd_char();
        return 8'h61 + 8'($urandom_range(0, 1));
    endfunction

    function automatic int rnd_len();
        if ($urandom_range(0, 9) == 0) return 0;
        return int'($urandom_range(1, WL));
    endfunction

    task automatic test_random();
        int cyc;
        int be;
        int ecyc;
        int wl;
        bit m;
        logic [WW-1:0] w;
        logic [RW-1:0] res;
        logic [RW-1:0] exp;
        for (int a = 0; a < DEPTH; a++) begin
            write_entry(a, w3(rnd_char(), rnd_char(), rnd_char()), rnd_len());
        end
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 3)) begin
                write_entry(int'($urandom_range(0, DEPTH - 1)),
                            w3(rnd_char(), rnd_char(), rnd_char()), rnd_len());
            end
            w  = w3(rnd_char(), rnd_char(), rnd_char());
            wl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, WL));
            m  = 1'($urandom_range(0, 1));
            model(w, wl, m, exp, ecyc);
            run_query(w, wl, m, cyc, res, be);
            total++;
            if (res !== exp || cyc != ecyc || be != 0) begin
                bad++;
                $display("FAIL random_%0d: w %h len %0d mode %0d res %h cyc %0d busy_err %0d want %h cyc %0d",
                         it, w, wl, m, res, cyc, be, exp, ecyc);
            end
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.word     = '0;
        bus.word_len = '0;
        bus.mode     = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_len   = '0;
        for (int a = 0; a < DEPTH; a++) begin
            m_data[a] = '0;
            m_len[a]  = 0;
        end
        test_reset();
        test_exact();
        test_prefix();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midscan();
        test_zero_len();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
